// File: rtl/fp_divider.sv
// fp_divider: IEEE-754 single-precision divider, z = a / b.
// Ports: clk, rst (sync, active-high); input_a/_stb/_ack, input_b/_stb/_ack,
//   output_z/_stb/_ack. Multi-cycle FSM, one restoring division bit per cycle.
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL,
    NORM_A, NORM_B, DIV_INIT, DIV_ITER,
    DIV_DONE, NORM_SUB, ROUND, PACK, PUT_Z
  } state_t;

  state_t r_state, w_next;

  logic [31:0] r_a, r_b, r_z, r_z_out;
  logic        r_a_ack, r_b_ack, r_z_stb;
  logic [23:0] r_a_m, r_b_m, r_z_m;
  logic signed [9:0] r_a_e, r_b_e, r_z_e;
  logic        r_z_s, r_g, r_r, r_st;
  logic [26:0] r_q;
  logic [25:0] r_rem;
  logic [4:0]  r_cnt;

  assign input_a_ack  = r_a_ack;
  assign input_b_ack  = r_b_ack;
  assign output_z     = r_z_out;
  assign output_z_stb = r_z_stb;

  logic w_a_max, w_b_max, w_a_fnz, w_b_fnz;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic w_a_zero, w_b_zero, w_sgn, w_special;
  logic [31:0] w_spec_z;

  assign w_a_max  = &r_a[30:23];
  assign w_b_max  = &r_b[30:23];
  assign w_a_fnz  = |r_a[22:0];
  assign w_b_fnz  = |r_b[22:0];
  assign w_a_nan  = w_a_max & w_a_fnz;
  assign w_b_nan  = w_b_max & w_b_fnz;
  assign w_a_inf  = w_a_max & ~w_a_fnz;
  assign w_b_inf  = w_b_max & ~w_b_fnz;
  assign w_a_zero = ~|r_a[30:0];
  assign w_b_zero = ~|r_b[30:0];
  assign w_sgn    = r_a[31] ^ r_b[31];

  always_comb begin
    w_special = 1'b1;
    w_spec_z  = 32'hFFC00000;
    if (w_a_nan || w_b_nan ||
        (w_a_zero && w_b_zero) ||
        (w_a_inf && w_b_inf))
      w_spec_z = 32'hFFC00000;
    else if (w_a_inf || w_b_zero)
      w_spec_z = {w_sgn, 8'hFF, 23'd0};
    else if (w_b_inf || w_a_zero)
      w_spec_z = {w_sgn, 31'd0};
    else
      w_special = 1'b0;
  end

  logic        w_div_ge;
  logic [24:0] w_div_rem;
  assign w_div_ge  = r_rem >= {2'b00, r_b_m};
  assign w_div_rem = w_div_ge ?
    25'(r_rem - {2'b00, r_b_m}) : r_rem[24:0];

  logic       w_rnd_up;
  logic [7:0] w_bexp;
  logic [31:0] w_pack;
  assign w_rnd_up = r_g & (r_r | r_st | r_z_m[0]);
  assign w_bexp   = r_z_e[7:0] + 8'd127;

  always_comb begin
    w_pack = {r_z_s, w_bexp, r_z_m[22:0]};
    if (r_z_e == -10'sd126 && !r_z_m[23])
      w_pack[30:23] = 8'd0;
    if (r_z_e > 10'sd127)
      w_pack = {r_z_s, 8'hFF, 23'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= GET_A;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      GET_A:    if (r_a_ack && input_a_stb) w_next = GET_B;
      GET_B:    if (r_b_ack && input_b_stb) w_next = UNPACK;
      UNPACK:   w_next = SPECIAL;
      SPECIAL:  w_next = w_special ? PUT_Z : NORM_A;
      NORM_A:   if (r_a_m[23]) w_next = NORM_B;
      NORM_B:   if (r_b_m[23]) w_next = DIV_INIT;
      DIV_INIT: w_next = DIV_ITER;
      DIV_ITER: if (r_cnt == 5'd26) w_next = DIV_DONE;
      DIV_DONE: w_next = NORM_SUB;
      NORM_SUB: if (!(r_z_e < -10'sd126)) w_next = ROUND;
      ROUND:    w_next = PACK;
      PACK:     w_next = PUT_Z;
      PUT_Z:    if (r_z_stb && output_z_ack) w_next = GET_A;
      default:  w_next = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_z_stb <= 1'b0;
      r_z_out <= 32'd0;
    end else begin
      unique case (r_state)
        GET_A: begin
          if (r_a_ack && input_a_stb) begin
            r_a     <= input_a;
            r_a_ack <= 1'b0;
          end else begin
            r_a_ack <= 1'b1;
          end
        end
        GET_B: begin
          if (r_b_ack && input_b_stb) begin
            r_b     <= input_b;
            r_b_ack <= 1'b0;
          end else begin
            r_b_ack <= 1'b1;
          end
        end
        UNPACK: begin
          r_a_m <= {|r_a[30:23], r_a[22:0]};
          r_b_m <= {|r_b[30:23], r_b[22:0]};
          r_a_e <= (r_a[30:23] == 8'd0) ? -10'sd126 :
            $signed({2'b00, r_a[30:23]}) - 10'sd127;
          r_b_e <= (r_b[30:23] == 8'd0) ? -10'sd126 :
            $signed({2'b00, r_b[30:23]}) - 10'sd127;
        end
        SPECIAL: r_z <= w_spec_z;
        NORM_A: begin
          if (!r_a_m[23]) begin
            r_a_m <= r_a_m << 1;
            r_a_e <= r_a_e - 10'sd1;
          end
        end
        NORM_B: begin
          if (!r_b_m[23]) begin
            r_b_m <= r_b_m << 1;
            r_b_e <= r_b_e - 10'sd1;
          end
        end
        DIV_INIT: begin
          r_z_s <= r_a[31] ^ r_b[31];
          r_z_e <= r_a_e - r_b_e;
          r_q   <= 27'd0;
          r_rem <= {2'b00, r_a_m};
          r_cnt <= 5'd0;
        end
        DIV_ITER: begin
          r_q   <= {r_q[25:0], w_div_ge};
          r_rem <= {w_div_rem, 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        DIV_DONE: begin
          if (r_q[26]) begin
            r_z_m <= r_q[26:3];
            r_g   <= r_q[2];
            r_r   <= r_q[1];
            r_st  <= r_q[0] | (r_rem != 26'd0);
          end else begin
            r_z_m <= r_q[25:2];
            r_g   <= r_q[1];
            r_r   <= r_q[0];
            r_st  <= r_rem != 26'd0;
            r_z_e <= r_z_e - 10'sd1;
          end
        end
        NORM_SUB: begin
          if (r_z_e < -10'sd126) begin
            r_z_e <= r_z_e + 10'sd1;
            r_z_m <= r_z_m >> 1;
            r_g   <= r_z_m[0];
            r_r   <= r_g;
            r_st  <= r_st | r_r;
          end
        end
        ROUND: begin
          if (w_rnd_up) begin
            r_z_m <= r_z_m + 24'd1;
            if (&r_z_m) r_z_e <= r_z_e + 10'sd1;
          end
        end
        PACK: r_z <= w_pack;
        PUT_Z: begin
          if (!r_z_stb) begin
            r_z_stb <= 1'b1;
            r_z_out <= r_z;
          end else if (output_z_ack) begin
            r_z_stb <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors for fp_divider.
// Checks reset, quotients, specials, range limits, handshake, latency.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        input_a_stb, input_b_stb;
  logic        input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb, output_z_ack;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b);
    bit ok;
    input_a = a;
    input_a_stb = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (input_a_ack) begin ok = 1; break; end
    end
    if (!ok) check("a_ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    input_b = b;
    input_b_stb = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (input_b_ack) begin ok = 1; break; end
    end
    if (!ok) check("b_ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 input_b_stb = 1'b0;
  endtask

  task automatic wait_z(output int lat);
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (output_z_stb) break;
    end
    if (!output_z_stb) check("z_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_z();
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp,
                     input bit chk_lat);
    int lat;
    send(a, b);
    wait_z(lat);
    check(tag, output_z, exp);
    if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'd37);
    release_z();
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    bit          lat;
  } vec_t;

  vec_t vecs [16] = '{
    '{"six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1},
    '{"one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b1},
    '{"one_one",     32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1},
    '{"neg_six_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b1},
    '{"neg_div_0",   32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0},
    '{"zero_zero",   32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0},
    '{"one_div_inf", 32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0},
    '{"nan_a",       32'h7FC00000, 32'h3F800000, 32'hFFC00000, 1'b0},
    '{"inf_inf",     32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0},
    '{"inf_neg2",    32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0},
    '{"negzero_2",   32'h80000000, 32'h40000000, 32'h80000000, 1'b0},
    '{"overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0},
    '{"sub_result",  32'h00800000, 32'h40000000, 32'h00400000, 1'b0},
    '{"sub_input",   32'h00400000, 32'h3F800000, 32'h00400000, 1'b0},
    '{"tie_to_zero", 32'h00000001, 32'h40000000, 32'h00000000, 1'b0},
    '{"tie_to_even", 32'h00000003, 32'h40000000, 32'h00000002, 1'b0}
  };

  initial begin
    int lat;
    bit stray;
    rst = 1'b1;
    input_a = '0;
    input_b = '0;
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ack", 32'(input_a_ack), 32'd0);
    check("rst_b_ack", 32'(input_b_ack), 32'd0);
    check("rst_z_stb", 32'(output_z_stb), 32'd0);
    check("rst_z", output_z, 32'd0);
    rst = 1'b0;

    output_z_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ack_idle_a_ack", 32'(input_a_ack), 32'd1);
    check("ack_idle_z_stb", 32'(output_z_stb), 32'd0);
    output_z_ack = 1'b0;

    foreach (vecs[i])
      run(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].lat);

    send(32'h40C00000, 32'h40000000);
    wait_z(lat);
    check("hold_lat", 32'(lat), 32'd37);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_stb", 32'(output_z_stb), 32'd1);
      check("hold_z", output_z, 32'h40400000);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    check("rel_stb", 32'(output_z_stb), 32'd0);
    check("rel_a_ack0", 32'(input_a_ack), 32'd0);
    @(posedge clk);
    #1;
    check("rel_a_ack1", 32'(input_a_ack), 32'd1);

    send(32'h3F800000, 32'h40400000);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_stb", 32'(output_z_stb), 32'd0);
    check("mid_rst_z", output_z, 32'd0);
    check("mid_rst_a_ack", 32'(input_a_ack), 32'd0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) stray = 1;
    end
    check("no_stale", 32'(stray), 32'd0);
    run("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
Parameters: none.
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port input_a, input, 32, IEEE-754 single-precision dividend, in softmax the exp term.
REQ-004 SHALL have port input_a_stb, input, 1, input_a valid.
REQ-005 SHALL have port input_a_ack, output, 1, block ready for input_a.
REQ-006 SHALL have port input_b, input, 32, IEEE-754 single-precision divisor, in softmax the adder's sum.
REQ-007 SHALL have port input_b_stb, input, 1, input_b valid.
REQ-008 SHALL have port input_b_ack, output, 1, block ready for input_b.
REQ-009 SHALL have port output_z, output, 32, quotient a/b.
REQ-010 SHALL have port output_z_stb, output, 1, output_z valid.
REQ-011 SHALL have port output_z_ack, input, 1, consumer accepts output_z.

Function
REQ-012 SHALL step the FSM once per clk edge through GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT, DIV_ITER, DIV_DONE, NORM_SUB, ROUND, PACK, PUT_Z.
REQ-013 GET_A: SHALL register input_a_ack=1; on an edge with input_a_ack and input_a_stb both high, SHALL capture input_a, clear ack next cycle, and go to GET_B; a stb without ack is ignored.
REQ-014 GET_B: SHALL follow the same protocol on the b ports, then go to UNPACK.
REQ-015 UNPACK: SHALL take 24-bit mantissas with the hidden bit set for normal operands and clear for subnormal ones; SHALL take 10-bit signed unbiased exponents (exp-127; -126 for subnormals).
REQ-016 SPECIAL: SHALL resolve the following in priority order, set z, and go directly to PUT_Z:
- a or b NaN, 0/0, or inf/inf -> 0xFFC00000.
- a inf -> inf, sign a_s^b_s.
- b zero -> inf, sign a_s^b_s.
- b inf -> signed zero.
- a zero -> signed zero.
REQ-017 In all other cases SPECIAL SHALL go to NORM_A.
REQ-018 NORM_A/NORM_B: while mantissa bit23==0, SHALL shift the mantissa left one bit and decrement its exponent, one bit per cycle.
REQ-019 DIV_INIT: SHALL set z_s=a_s^b_s and z_e=a_e-b_e; SHALL clear the quotient and load the remainder with a_m.
REQ-020 DIV_ITER: SHALL run restoring division for exactly 27 cycles, producing one quotient bit per cycle, Q=floor(a_m*2^26/b_m), Q 27 bits wide.
REQ-021 DIV_DONE, when Q[26]=1: SHALL set z_m=Q[26:3], guard=Q[2], round=Q[1], sticky=Q[0] OR (remainder!=0).
REQ-022 DIV_DONE, when Q[26]=0: SHALL set z_m=Q[25:2], guard=Q[1], round=Q[0], sticky=(remainder!=0), and decrement z_e.
REQ-023 NORM_SUB: while z_e<-126, SHALL increment z_e, shift z_m right, and shift bits through guard/round into sticky; one bit per cycle.
REQ-024 ROUND: SHALL round to nearest, ties to even (increment if guard AND (round OR sticky OR z_m[0])); carry out of 0xFFFFFF SHALL increment z_e.
REQ-025 PACK: SHALL set biased exponent = z_e+127.
REQ-026 PACK: if z_e==-126 and z_m[23]==0, SHALL set exponent 0 (subnormal or zero).
REQ-027 PACK: if z_e>127, SHALL output signed inf.
REQ-028 PUT_Z: SHALL drive output_z_stb=1 with output_z=z; output_z SHALL stay stable while stb is high; on an edge with stb AND output_z_ack, SHALL clear stb next cycle and return to GET_A.
REQ-029 For normal operands with a normal result, output_z_stb SHALL first be high 37 edges after the edge that accepts b.
REQ-030 output_z_ack high outside PUT_Z SHALL have no effect.

Reset
REQ-031 While rst=1, SHALL force state=GET_A, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0; in-flight operands SHALL be discarded.
REQ-032 With rst asserted mid-division, the first output after rst deasserts SHALL reflect only operands transferred after reset.

Verification
REQ-033 0x40C00000 / 0x40000000 (6.0/2.0) -> output_z=0x40400000, stb at the 37th edge after b accepted.
REQ-034 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up path).
REQ-035 Special cases:
- 0xBF800000/0x00000000 -> 0xFF800000.
- 0x00000000/0x00000000 -> 0xFFC00000.
- 0x3F800000/0x7F800000 -> 0x00000000.
REQ-036 Range limits:
- 0x7F7FFFFF/0x3F000000 -> 0x7F800000 (overflow).
- 0x00800000/0x40000000 -> 0x00400000 (subnormal).
- 0x00400000/0x3F800000 -> 0x00400000 (subnormal input).
REQ-037 Hold output_z_ack=0 for 10 cycles in PUT_Z -> stb and output_z stay constant; ack=1 -> stb low next cycle, input_a_ack high the cycle after.
REQ-038 Assert rst during DIV_ITER, then send 6.0/2.0 -> only 0x40400000 is produced, with no stale result.
